fp_sum4_gather: RTL and testbench

//  Upstream feeder for the 4-input fp32 adder (fp_adder4). Collects a serial valid/ready stream of
//  fp32 words into groups of four and fires each group into the adder. Registers the sum on a

---
 rtl/fp_pkg.sv | 19 +
 rtl/fp_adder4.sv | 49 ++++
 rtl/fp_sum4_gather.sv | 62 ++++++
 tb/tb_fp_sum4_gather.sv | 222 ++++++++++++++++++++++
 4 files changed

// File: rtl/fp_pkg.sv
// Shared fp32 definitions: field widths and field slice helpers.
package fp_pkg;
    localparam int FP_W  = 32;
    localparam int EXP_W = 8;
    localparam int MAN_W = 23;
    localparam logic [FP_W-1:0] FP_ZERO = 32'h0000_0000;

    function automatic logic fp_sign(input logic [FP_W-1:0] x);
        return x[FP_W-1];
    endfunction

    function automatic logic [EXP_W-1:0] fp_exp(input logic [FP_W-1:0] x);
        return x[FP_W-2 -: EXP_W];
    endfunction

    function automatic logic [MAN_W-1:0] fp_man(input logic [FP_W-1:0] x);
        return x[MAN_W-1:0];
    endfunction
endpackage

// File: rtl/fp_adder4.sv
// Combinational 4-input fp32 adder: align to max exponent, signed sum, normalise.
// Truncating at every step; no NaN/Inf/denormal handling (hidden bit always assumed).
module fp_adder4
    import fp_pkg::*;
(
    input  logic [3:0][FP_W-1:0] ops,
    output logic [FP_W-1:0]      sum
);
    localparam int AL_W  = MAN_W + 4;   // hidden bit + mantissa + 3 guard bits
    localparam int ACC_W = AL_W + 3;    // headroom for 4 signed terms

    logic [EXP_W-1:0] max_e, d, exp_r;
    logic [AL_W-1:0]  al;
    logic [ACC_W-1:0] acc, term, mag, norm;
    logic [4:0]       lead;
    logic             neg;
    logic [MAN_W-1:0] man_r;

    always_comb begin
        max_e = '0;
        for (int i = 0; i < 4; i++)
            if (fp_exp(ops[i]) > max_e) max_e = fp_exp(ops[i]);

        acc  = '0;
        d    = '0;
        al   = '0;
        term = '0;
        for (int i = 0; i < 4; i++) begin
            d  = max_e - fp_exp(ops[i]);
            al = {1'b1, fp_man(ops[i]), 3'b000};
            // Terms shifted by the full aligned width vanish entirely.
            al   = (d >= 8'(AL_W)) ? '0 : (al >> d);
            term = {3'b000, al};
            acc  = fp_sign(ops[i]) ? (acc - term) : (acc + term);
        end

        neg = acc[ACC_W-1];
        mag = neg ? (~acc + 1'b1) : acc;

        lead = '0;
        for (int p = 0; p < ACC_W; p++)
            if (mag[p]) lead = 5'(p);

        exp_r = max_e + {3'b000, lead} - 8'(AL_W - 1);
        norm  = mag << (5'(ACC_W - 1) - lead);
        man_r = MAN_W'(norm >> (ACC_W - 1 - MAN_W));
        sum   = (mag == '0) ? FP_ZERO : {neg, exp_r, man_r};
    end
endmodule

// File: rtl/fp_sum4_gather.sv
// Gathers a serial fp32 stream into groups of four (or shorter on in_last),
// sums each group with fp_adder4 and holds the result on a valid/ready output.
module fp_sum4_gather
    import fp_pkg::*;
#(
    parameter logic [FP_W-1:0] PAD_WORD = FP_ZERO
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic [FP_W-1:0] in_data,
    input  logic            in_valid,
    input  logic            in_last,
    output logic            in_ready,
    output logic [FP_W-1:0] out_data,
    output logic [2:0]      out_count,
    output logic            out_valid,
    input  logic            out_ready
);
    logic [3:0][FP_W-1:0] slots;
    logic [2:0]           cnt;
    logic                 closed;
    logic [FP_W-1:0]      sum;
    logic                 accept, fire;

    fp_adder4 u_add (
        .ops (slots),
        .sum (sum)
    );

    assign in_ready = !closed;
    assign accept   = in_valid && !closed;
    // A closed group waits here until the output register is free or draining.
    assign fire     = closed && (!out_valid || out_ready);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            slots     <= {4{PAD_WORD}};
            cnt       <= '0;
            closed    <= 1'b0;
            out_data  <= '0;
            out_count <= '0;
            out_valid <= 1'b0;
        end else begin
            if (fire) begin
                out_data  <= sum;
                out_count <= cnt;
                out_valid <= 1'b1;
                slots     <= {4{PAD_WORD}};
                cnt       <= '0;
                closed    <= 1'b0;
            end else if (out_valid && out_ready) begin
                out_valid <= 1'b0;
            end

            if (accept) begin
                slots[cnt[1:0]] <= in_data;
                cnt             <= cnt + 3'd1;
                if (cnt == 3'd3 || in_last) closed <= 1'b1;
            end
        end
    end
endmodule

// File: tb/tb_fp_sum4_gather.sv
// Directed bench for fp_sum4_gather with a queue scoreboard and output monitor.
module tb_fp_sum4_gather;
    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [31:0] in_data = '0;
    logic        in_valid = 1'b0;
    logic        in_last = 1'b0;
    logic        in_ready;
    logic [31:0] out_data;
    logic [2:0]  out_count;
    logic        out_valid;
    logic        out_ready = 1'b0;

    fp_sum4_gather dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_data   (in_data),
        .in_valid  (in_valid),
        .in_last   (in_last),
        .in_ready  (in_ready),
        .out_data  (out_data),
        .out_count (out_count),
        .out_valid (out_valid),
        .out_ready (out_ready)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [31:0] d;
        logic [2:0]  c;
    } exp_t;

    exp_t sb[$];
    exp_t e;
    int   errors = 0, checks = 0;
    bit   win = 1'b0;
    int   low_cnt = 0, pop_cnt = 0;

    localparam logic [31:0] F1  = 32'h3F80_0000;  // 1.0
    localparam logic [31:0] FM1 = 32'hBF80_0000;  // -1.0
    localparam logic [31:0] F2  = 32'h4000_0000;  // 2.0
    localparam logic [31:0] F3  = 32'h4040_0000;  // 3.0
    localparam logic [31:0] F4  = 32'h4080_0000;  // 4.0
    localparam logic [31:0] F8  = 32'h4100_0000;  // 8.0

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %h want %h", name, act, req);
        end
    endtask

    task automatic push(input logic [31:0] d, input logic [2:0] c);
        sb.push_back({d, c});
    endtask

    // Monitor: outputs are stable at the falling edge; a handshake seen here completes next rising edge.
    always @(negedge clk) begin
        if (rst_n && out_valid && out_ready) begin
            if (sb.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_output: got %h/%0d want none", out_data, out_count);
            end else begin
                e = sb.pop_front();
                chk("out_data", out_data, e.d);
                chk("out_count", 32'(out_count), 32'(e.c));
            end
            if (win) pop_cnt++;
        end
    end

    always @(negedge clk)
        if (win && !in_ready) low_cnt++;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [31:0] d, input logic last);
        int n = 0;
        in_data  = d;
        in_valid = 1'b1;
        in_last  = last;
        while (!in_ready && n < 50) begin
            tick();
            n++;
        end
        if (!in_ready) begin
            checks++;
            errors++;
            $display("FAIL send_timeout: in_ready got 0 want 1");
        end
        tick();
    endtask

    task automatic idle();
        in_valid = 1'b0;
        in_last  = 1'b0;
    endtask

    task automatic drain();
        int n = 0;
        while (sb.size() != 0 && n < 100) begin
            tick();
            n++;
        end
        chk("drain_empty", 32'(sb.size()), 32'd0);
    endtask

    initial begin
        // reset state
        repeat (2) @(posedge clk);
        #1;
        chk("rst_in_ready", 32'(in_ready), 32'd1);
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        chk("rst_out_data", out_data, 32'd0);
        chk("rst_out_count", 32'(out_count), 32'd0);
        rst_n = 1'b1;
        tick();

        // 1: four ones, latency of two edges after the 4th word
        out_ready = 1'b1;
        push(F4, 3'd4);
        for (int i = 0; i < 4; i++) send(F1, 1'b0);
        idle();
        chk("t1_close_edge_valid", 32'(out_valid), 32'd0);
        chk("t1_close_in_ready", 32'(in_ready), 32'd0);
        tick();
        chk("t1_fire_edge_valid", 32'(out_valid), 32'd1);
        drain();

        // 2: mixed signs and exponents
        push(F3, 3'd4);
        send(F1, 1'b0); send(F1, 1'b0); send(FM1, 1'b0); send(F2, 1'b0);
        idle();
        drain();

        // 3: short group on in_last, then next group restarts at slot0;
        //    in_last without in_valid in between must be ignored
        push(F4, 3'd2);
        send(F2, 1'b0); send(F2, 1'b1);
        idle();
        tick();
        in_last = 1'b1;
        tick();
        in_last = 1'b0;
        push(F3, 3'd4);
        send(F1, 1'b0); send(F1, 1'b0); send(FM1, 1'b0); send(F2, 1'b0);
        idle();
        drain();

        // group of one
        push(F3, 3'd1);
        send(F3, 1'b1);
        idle();
        drain();

        // 4: output stalled, two groups queue up without loss
        out_ready = 1'b0;
        push(F4, 3'd4);
        push(F8, 3'd4);
        for (int i = 0; i < 4; i++) send(F1, 1'b0);
        for (int i = 0; i < 4; i++) send(F2, 1'b0);
        idle();
        chk("t4_stall_in_ready", 32'(in_ready), 32'd0);
        repeat (5) tick();
        chk("t4_hold_in_ready", 32'(in_ready), 32'd0);
        chk("t4_hold_valid", 32'(out_valid), 32'd1);
        chk("t4_hold_data", out_data, F4);
        chk("t4_hold_count", 32'(out_count), 32'd4);
        out_ready = 1'b1;
        drain();
        repeat (2) tick();
        chk("t4_valid_drop", 32'(out_valid), 32'd0);

        // 5: back-to-back groups
        low_cnt = 0;
        pop_cnt = 0;
        win = 1'b1;
        push(F4, 3'd4);
        push(F3, 3'd4);
        push(F8, 3'd4);
        for (int i = 0; i < 4; i++) send(F1, 1'b0);
        send(F1, 1'b0); send(F1, 1'b0); send(FM1, 1'b0); send(F2, 1'b0);
        for (int i = 0; i < 4; i++) send(F2, 1'b0);
        idle();
        repeat (4) tick();
        win = 1'b0;
        chk("t5_in_ready_low_cycles", 32'(low_cnt), 32'd3);
        chk("t5_outputs", 32'(pop_cnt), 32'd3);
        drain();

        // 6: reset mid-group with a pending stalled result
        out_ready = 1'b0;
        send(F1, 1'b1);
        idle();
        repeat (2) tick();
        chk("t6_pending_valid", 32'(out_valid), 32'd1);
        send(F1, 1'b0); send(F1, 1'b0);
        idle();
        rst_n = 1'b0;
        #1;
        chk("t6_rst_valid", 32'(out_valid), 32'd0);
        chk("t6_rst_in_ready", 32'(in_ready), 32'd1);
        chk("t6_rst_data", out_data, 32'd0);
        tick();
        rst_n = 1'b1;
        out_ready = 1'b1;
        push(F4, 3'd4);
        for (int i = 0; i < 4; i++) send(F1, 1'b0);
        idle();
        drain();
        repeat (3) tick();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
